// File: rtl/wb_host_pkg.sv
// Shared types and constants for the single-outstanding Wishbone host master.
package wb_host_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

    // Bits needed to count 0..cycles inclusive.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wb_host_timeout.sv
// Bus-wait watchdog: up-counter with synchronous clear and enable; expired flags
// the last permitted wait cycle so the owner can abort on that edge.
module wb_host_timeout
    import wb_host_pkg::*;
#(
    parameter int LIMIT = 255,
    parameter int CW    = cnt_width(LIMIT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Count equals the number of completed wait cycles, so the LIMIT-th bus
    // cycle is the one where count == LIMIT-1.
    assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone B3 classic initiator: one bus cycle per command.
// Optional ack watchdog enabled by defining WB_HOST_TIMEOUT_EN.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int               ADR_W          = 32,
    parameter int               DAT_W          = 32,
    parameter int               TIMEOUT_CYCLES = 255,
    parameter logic [DAT_W-1:0] ERR_DATA       = DAT_W'(ERR_DATA_DEF)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADR_W-1:0]     cmd_adr_i,
    input  logic [DAT_W-1:0]     cmd_dat_i,
    input  logic [DAT_W/8-1:0]   cmd_sel_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DAT_W-1:0]     rsp_dat_o,
    output logic                 rsp_err_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [DAT_W/8-1:0]   wbm_sel_o,
    output logic [ADR_W-1:0]     wbm_adr_o,
    output logic [DAT_W-1:0]     wbm_dat_o,
    input  logic                 wbm_ack_i,
    input  logic [DAT_W-1:0]     wbm_dat_i
);

    state_t               state_q, state_d;
    logic                 cyc_d, stb_d, we_d;
    logic [DAT_W/8-1:0]   sel_d;
    logic [ADR_W-1:0]     adr_d;
    logic [DAT_W-1:0]     dat_d;
    logic                 rsp_valid_d, rsp_err_d;
    logic [DAT_W-1:0]     rsp_dat_d;
    logic                 timeout_hit;

`ifdef WB_HOST_TIMEOUT_EN
    logic to_expired;

    wb_host_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .clr     (state_q != BUS),
        .en      ((state_q == BUS) && !wbm_ack_i),
        .expired (to_expired)
    );

    assign timeout_hit = to_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    assign cmd_ready_o = (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        cyc_d       = wbm_cyc_o;
        stb_d       = wbm_stb_o;
        we_d        = wbm_we_o;
        sel_d       = wbm_sel_o;
        adr_d       = wbm_adr_o;
        dat_d       = wbm_dat_o;
        rsp_valid_d = rsp_valid_o;
        rsp_dat_d   = rsp_dat_o;
        rsp_err_d   = rsp_err_o;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                end
            end
            BUS: begin
                // An ack on the timeout edge still completes normally.
                if (wbm_ack_i || timeout_hit) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = '0;
                    dat_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !wbm_ack_i;
                    if (wbm_we_o)
                        rsp_dat_d = '0;
                    else if (wbm_ack_i)
                        rsp_dat_d = wbm_dat_i;
                    else
                        rsp_dat_d = ERR_DATA;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= IDLE;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wbm_cyc_o   <= cyc_d;
            wbm_stb_o   <= stb_d;
            wbm_we_o    <= we_d;
            wbm_sel_o   <= sel_d;
            wbm_adr_o   <= adr_d;
            wbm_dat_o   <= dat_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_dat_o   <= rsp_dat_d;
            rsp_err_o   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench for wb_host_master: vector table, hand-written corner
// sequences and an in-order response scoreboard.
module tb_wb_host_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_adr_i, cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_dat_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

    wb_host_master #(
        .ADR_W          (32),
        .DAT_W          (32),
        .TIMEOUT_CYCLES (8),
        .ERR_DATA       (32'hFFFF_FFFF)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_n_i  (wb_rst_n_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .cmd_sel_i   (cmd_sel_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          bc;      // cycles cyc is high; ack on the last one
        logic [31:0] rdata;
        int          hold;    // response backpressure cycles; <0 = ready held high
        logic [31:0] exp_dat;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    int   checks = 0;
    int   fails  = 0;
    rsp_t sb[$];
    vec_t tbl[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Offer a command, play the slave, then consume the response.
    task automatic run_cmd(input vec_t v, input logic exp_err);
        logic acc;
        int   n;
        rsp_ready_i = (v.hold < 0);
        cmd_valid_i = 1'b1;
        cmd_we_i    = v.we;
        cmd_adr_i   = v.adr;
        cmd_dat_i   = v.dat;
        cmd_sel_i   = v.sel;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 10) begin
            acc = cmd_ready_o;
            tick();
            n++;
        end
        cmd_valid_i = 1'b0;
        chk("cmd_accept", {63'd0, acc}, 64'd1);
        if (!acc) return;
        sb.push_back('{v.exp_dat, exp_err});
        for (int i = 1; i <= v.bc; i++) begin
            chk("bus_cyc_stb", {62'd0, wbm_cyc_o, wbm_stb_o}, 64'd3);
            chk("bus_fields", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
                {v.we, v.sel, v.adr, v.dat});
            chk("rsp_quiet_in_bus", {63'd0, rsp_valid_o}, 64'd0);
            if (i == v.bc) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = v.rdata;
            end
            tick();
            wbm_ack_i = 1'b0;
            wbm_dat_i = $urandom;
        end
        chk("rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
        chk("rsp_dat", {32'd0, rsp_dat_o}, {32'd0, v.exp_dat});
        chk("bus_cleared", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_dat_o}, 64'd0);
        chk("adr_hold", {32'd0, wbm_adr_o}, {32'd0, v.adr});
        if (v.hold >= 0) begin
            cmd_valid_i = 1'b1;
            cmd_adr_i   = 32'h3000_0F00;
            for (int i = 0; i < v.hold; i++) begin
                tick();
                chk("bp_valid", {63'd0, rsp_valid_o}, 64'd1);
                chk("bp_dat", {32'd0, rsp_dat_o}, {32'd0, v.exp_dat});
                chk("bp_cmd_ready", {63'd0, cmd_ready_o}, 64'd0);
                chk("bp_no_cyc", {63'd0, wbm_cyc_o}, 64'd0);
            end
            rsp_ready_i = 1'b1;
            tick();
            cmd_valid_i = 1'b0;
            rsp_ready_i = 1'b0;
            chk("hs_valid_clear", {63'd0, rsp_valid_o}, 64'd0);
            chk("hs_cmd_ready", {63'd0, cmd_ready_o}, 64'd1);
            tick();
            chk("stale_cmd_not_taken", {63'd0, wbm_cyc_o}, 64'd0);
        end
    endtask

    // Scoreboard: the response leaves on the edge after a valid&&ready sample.
    initial forever begin
        @(negedge wb_clk_i);
        if (wb_rst_n_i && rsp_valid_o && rsp_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_unexpected actual=%0h required=none", rsp_dat_o);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("sb_dat", {32'd0, rsp_dat_o}, {32'd0, e.dat});
                chk("sb_err", {63'd0, rsp_err_o}, {63'd0, e.err});
            end
        end
    end

    // Idle gap between consecutive bus cycles.
    initial begin
        int   low_cnt;
        logic seen, prev;
        low_cnt = 0;
        seen    = 1'b0;
        prev    = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (!wb_rst_n_i) begin
                seen    = 1'b0;
                low_cnt = 0;
            end else if (wbm_cyc_o) begin
                if (!prev && seen)
                    chk("cyc_gap_ge2", {63'd0, (low_cnt >= 2)}, 64'd1);
                seen    = 1'b1;
                low_cnt = 0;
            end else begin
                low_cnt++;
            end
            prev = wbm_cyc_o;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t v;
        logic acc;
        int   n;
        wb_rst_n_i  = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        cmd_sel_i   = '0;
        rsp_ready_i = 1'b0;
        wbm_ack_i   = 1'b0;
        wbm_dat_i   = '0;

        tbl[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 1, 32'h1111_2222, 0, 32'h0};
        tbl[1] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 5, 32'hDEAD_0001, 4, 32'hDEAD_0001};
        tbl[2] = '{1'b1, 32'h3000_0100, 32'h0BAD_CAFE, 4'h3, 2, 32'h7777_7777, 1, 32'h0};
        tbl[3] = '{1'b0, 32'h3000_0FFC, 32'h0,         4'h1, 3, 32'h0000_00A5, 0, 32'h0000_00A5};

        #12;
        chk("rst_cmd_ready", {63'd0, cmd_ready_o}, 64'd1);
        chk("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_dat_o}, 64'd0);
        chk("rst_wbm_ctl", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 64'd0);
        chk("rst_wbm_bus", {wbm_adr_o, wbm_dat_o}, 64'd0);
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_cmd(tbl[i], 1'b0);

        // Spurious ack while idle must not disturb anything.
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h5555_AAAA;
        tick();
        wbm_ack_i = 1'b0;
        chk("spur_ack_idle", {61'd0, cmd_ready_o, rsp_valid_o, wbm_cyc_o}, 64'd4);
        chk("spur_ack_dat", {32'd0, rsp_dat_o}, {32'd0, tbl[3].exp_dat});
        tick();
        chk("spur_ack_late", {61'd0, cmd_ready_o, rsp_valid_o, wbm_cyc_o}, 64'd4);

        // Reset asserted between edges while the bus cycle is open.
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h3000_0020;
        cmd_sel_i   = 4'hF;
        tick();
        cmd_valid_i = 1'b0;
        chk("pre_rst_in_bus", {63'd0, wbm_cyc_o}, 64'd1);
        #2 wb_rst_n_i = 1'b0;
        #1;
        chk("async_rst_drop", {61'd0, wbm_cyc_o, wbm_stb_o, rsp_valid_o}, 64'd0);
        chk("async_rst_ready", {63'd0, cmd_ready_o}, 64'd1);
        #3 wb_rst_n_i = 1'b1;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        tick();
        wbm_ack_i = 1'b0;
        chk("late_ack_ignored", {61'd0, cmd_ready_o, rsp_valid_o, wbm_cyc_o}, 64'd4);
        tick();
        chk("late_ack_after", {61'd0, cmd_ready_o, rsp_valid_o, wbm_cyc_o}, 64'd4);

`ifdef WB_HOST_TIMEOUT_EN
        // Slave never answers: abort after 8 bus cycles with error data.
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h3000_0040;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 10) begin
            acc = cmd_ready_o;
            tick();
            n++;
        end
        cmd_valid_i = 1'b0;
        sb.push_back('{32'hFFFF_FFFF, 1'b1});
        n = 0;
        while (wbm_cyc_o && n < 40) begin
            n++;
            tick();
        end
        chk("to_bus_cycles", 64'(n), 64'd8);
        chk("to_rsp", {30'd0, rsp_valid_o, rsp_err_o, rsp_dat_o}, {30'd0, 2'b11, 32'hFFFF_FFFF});
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("to_hs", {63'd0, rsp_valid_o}, 64'd0);
        tick();

        // Ack on exactly the last allowed cycle completes normally.
        v = '{1'b0, 32'h3000_0044, 32'h0, 4'hF, 8, 32'hC0DE_0008, 0, 32'hC0DE_0008};
        run_cmd(v, 1'b0);
        chk("to_ack_wins_err", {63'd0, rsp_err_o}, 64'd0);
`endif

        // Streaming with ready held high and random wait states.
        for (int i = 0; i < 16; i++) begin
            v.we      = 1'($urandom_range(0, 1));
            v.adr     = $urandom & 32'hFFFF_FFFC;
            v.dat     = $urandom;
            v.sel     = 4'($urandom_range(1, 15));
            v.bc      = 1 + $urandom_range(0, 3);
            v.rdata   = $urandom;
            v.hold    = -1;
            v.exp_dat = v.we ? 32'h0 : v.rdata;
            run_cmd(v, 1'b0);
        end
        tick();
        tick();
        tick();
        rsp_ready_i = 1'b0;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("end_idle", {62'd0, cmd_ready_o, wbm_cyc_o}, 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
